// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, the global pipeline enable and
// the IF/ID and ID/EX flush strobes, and runs the IDLE / RUN / STEP_WAIT /
// DRAIN / HALTED control flow, including the drain window after HALT decode.
module pc_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pcjump,
  input  logic                  i_branch_taken,
  input  logic [DATA_WIDTH-1:0] i_branch_pc,
  input  logic                  i_halt,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_pipe_en,
  output logic                  o_flush_ifid,
  output logic                  o_flush_idex,
  output logic                  o_running,
  output logic                  o_halted,
  output logic [DATA_WIDTH-1:0] o_cycle_count
);

  // Drain counter only needs to hold DRAIN_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP_WAIT,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] count_next;
  logic [CNT_W-1:0]      drain_cnt, drain_next;
  logic                  step_mode, step_mode_next;
  logic                  advance;

  // Next-state, next-PC and all combinational outputs; defaults hold everything.
  always_comb begin
    state_next     = state;
    pc_next        = o_pc;
    count_next     = o_cycle_count;
    drain_next     = drain_cnt;
    step_mode_next = step_mode;
    advance        = 1'b0;
    o_flush_ifid   = 1'b0;
    o_flush_idex   = 1'b0;
    o_running      = 1'b0;
    o_halted       = 1'b0;

    case (state)
      S_IDLE, S_HALTED: begin
        o_halted = (state == S_HALTED);
        if (i_start) begin
          pc_next        = '0;
          count_next     = '0;
          step_mode_next = i_step_mode;
          state_next     = i_step_mode ? S_STEP_WAIT : S_RUN;
        end
      end

      S_RUN, S_STEP_WAIT: begin
        o_running = 1'b1;
        advance   = (state == S_RUN) || i_step;
        if (advance) begin
          if (i_branch_taken) begin
            pc_next      = i_branch_pc;
            o_flush_ifid = 1'b1;
            o_flush_idex = 1'b1;
          end else if (i_stall) begin
            pc_next = o_pc;
          end else if (i_halt) begin
            state_next = S_DRAIN;
            drain_next = CNT_W'(DRAIN_CYCLES - 1);
          end else if (i_jump) begin
            pc_next      = i_pcjump;
            o_flush_ifid = 1'b1;
          end else begin
            pc_next = o_pc + DATA_WIDTH'(1);
          end
        end
      end

      S_DRAIN: begin
        advance      = 1'b1;
        o_flush_ifid = 1'b1;
        if (i_branch_taken) begin
          pc_next      = i_branch_pc;
          o_flush_idex = 1'b1;
          drain_next   = '0;
          state_next   = step_mode ? S_STEP_WAIT : S_RUN;
        end else if (drain_cnt == '0) begin
          state_next = S_HALTED;
        end else begin
          drain_next = drain_cnt - CNT_W'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (advance && (o_cycle_count != {DATA_WIDTH{1'b1}})) begin
      count_next = o_cycle_count + DATA_WIDTH'(1);
    end
  end

  assign o_pipe_en = advance;

  // State, PC, cycle counter, drain counter and latched step mode registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      o_pc          <= '0;
      o_cycle_count <= '0;
      drain_cnt     <= '0;
      step_mode     <= 1'b0;
    end else begin
      state         <= state_next;
      o_pc          <= pc_next;
      o_cycle_count <= count_next;
      drain_cnt     <= drain_next;
      step_mode     <= step_mode_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus a random run, all
// checked cycle by cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_step_mode = 1'b0;
  logic         i_step = 1'b0;
  logic         i_stall = 1'b0;
  logic         i_jump = 1'b0;
  logic [W-1:0] i_pcjump = '0;
  logic         i_branch_taken = 1'b0;
  logic [W-1:0] i_branch_pc = '0;
  logic         i_halt = 1'b0;
  logic [W-1:0] o_pc;
  logic         o_pipe_en;
  logic         o_flush_ifid;
  logic         o_flush_idex;
  logic         o_running;
  logic         o_halted;
  logic [W-1:0] o_cycle_count;

  int total = 0;
  int bad   = 0;

  // Reference model: "live" = fetching (free run or waiting for steps),
  // "draining" = retiring after HALT, "halted" = stopped; none set = idle.
  logic         m_live, m_draining, m_halted, m_stepmode;
  int           m_left;
  logic [W-1:0] m_pc, m_cnt;

  pc_sequencer #(.DATA_WIDTH(W), .DRAIN_CYCLES(DC)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_start        (i_start),
    .i_step_mode    (i_step_mode),
    .i_step         (i_step),
    .i_stall        (i_stall),
    .i_jump         (i_jump),
    .i_pcjump       (i_pcjump),
    .i_branch_taken (i_branch_taken),
    .i_branch_pc    (i_branch_pc),
    .i_halt         (i_halt),
    .o_pc           (o_pc),
    .o_pipe_en      (o_pipe_en),
    .o_flush_ifid   (o_flush_ifid),
    .o_flush_idex   (o_flush_idex),
    .o_running      (o_running),
    .o_halted       (o_halted),
    .o_cycle_count  (o_cycle_count)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_live     = 1'b0;
    m_draining = 1'b0;
    m_halted   = 1'b0;
    m_stepmode = 1'b0;
    m_left     = 0;
    m_pc       = '0;
    m_cnt      = '0;
  endtask

  // Assert reset between clock edges and confirm outputs clear immediately.
  task automatic apply_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    i_start = 0; i_step_mode = 0; i_step = 0; i_stall = 0; i_jump = 0;
    i_branch_taken = 0; i_halt = 0; i_pcjump = '0; i_branch_pc = '0;
    #1;
    model_reset();
    check("rst_pc", o_pc, '0);
    check("rst_cnt", o_cycle_count, '0);
    check_bit("rst_pipe_en", o_pipe_en, 1'b0);
    check_bit("rst_flush_ifid", o_flush_ifid, 1'b0);
    check_bit("rst_flush_idex", o_flush_idex, 1'b0);
    check_bit("rst_running", o_running, 1'b0);
    check_bit("rst_halted", o_halted, 1'b0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic do_cycle(input logic start, input logic mode, input logic step,
                          input logic stall, input logic jump, input logic [W-1:0] pj,
                          input logic br, input logic [W-1:0] bpc, input logic halt);
    logic adv, e_ifid;
    @(negedge i_clk);
    i_start = start; i_step_mode = mode; i_step = step; i_stall = stall;
    i_jump = jump; i_pcjump = pj; i_branch_taken = br; i_branch_pc = bpc; i_halt = halt;
    #1;
    adv    = m_draining || (m_live && (!m_stepmode || step));
    e_ifid = adv && (br || m_draining || (!stall && !halt && jump));
    check("pc", o_pc, m_pc);
    check("cycle_count", o_cycle_count, m_cnt);
    check_bit("pipe_en", o_pipe_en, adv);
    check_bit("flush_ifid", o_flush_ifid, e_ifid);
    check_bit("flush_idex", o_flush_idex, adv && br);
    check_bit("running", o_running, m_live);
    check_bit("halted", o_halted, m_halted);
    @(posedge i_clk);
    if (adv) begin
      if (m_cnt != {W{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (br) begin
        m_pc = bpc;
        if (m_draining) begin
          m_draining = 1'b0;
          m_live     = 1'b1;
        end
      end else if (m_draining) begin
        if (m_left == 0) begin
          m_draining = 1'b0;
          m_halted   = 1'b1;
        end else begin
          m_left = m_left - 1;
        end
      end else if (stall) begin
        m_pc = m_pc;
      end else if (halt) begin
        m_live     = 1'b0;
        m_draining = 1'b1;
        m_left     = DC - 1;
      end else if (jump) begin
        m_pc = pj;
      end else begin
        m_pc = m_pc + 1'b1;
      end
    end else if (!m_live && !m_draining && start) begin
      m_pc       = '0;
      m_cnt      = '0;
      m_stepmode = mode;
      m_live     = 1'b1;
      m_halted   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(0, 0, 0, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic start_seq(input logic mode);
    do_cycle(1, mode, 0, 0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check("por_pc", o_pc, '0);
    check_bit("por_running", o_running, 1'b0);
    apply_reset();

    // Free run from start: PC counts 0..5.
    start_seq(0);
    idle(5);
    #1;
    check("free_pc5", o_pc, 8'd5);
    check("free_cnt5", o_cycle_count, 8'd5);

    // Jump redirect at pc=3.
    apply_reset();
    start_seq(0);
    idle(3);
    do_cycle(0, 0, 0, 0, 1, 8'h10, 0, '0, 0);
    #1;
    check("jump_pc", o_pc, 8'h10);

    // Branch beats jump and stall at pc=7; then a lone stall holds.
    apply_reset();
    start_seq(0);
    idle(7);
    do_cycle(0, 0, 0, 1, 1, 8'h20, 1, 8'h40, 0);
    #1;
    check("prio_pc", o_pc, 8'h40);
    do_cycle(0, 0, 0, 1, 0, '0, 0, '0, 0);
    #1;
    check("stall_pc", o_pc, 8'h40);

    // Single-step mode: nothing moves without i_step; mode input changes are ignored.
    apply_reset();
    start_seq(1);
    idle(10);
    #1;
    check("step_wait_pc", o_pc, 8'd0);
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 0, 1, 0, 0, '0, 0, '0, 0);
      do_cycle(0, 0, 0, 0, 0, '0, 0, '0, 0);
    end
    #1;
    check("step_pc3", o_pc, 8'd3);
    check("step_cnt3", o_cycle_count, 8'd3);

    // Halt at pc=9: four drain cycles, then halted; start restarts from 0.
    apply_reset();
    start_seq(0);
    idle(9);
    do_cycle(0, 0, 0, 0, 1, 8'h33, 0, '0, 1);
    idle(DC);
    #1;
    check("drain_pc", o_pc, 8'd9);
    check_bit("halted_after_drain", o_halted, 1'b1);
    idle(2);
    start_seq(0);
    #1;
    check("restart_pc", o_pc, 8'd0);
    check_bit("restart_running", o_running, 1'b1);
    idle(2);

    // Async reset in the middle of DRAIN, then steps with no start are ignored.
    apply_reset();
    start_seq(0);
    idle(9);
    do_cycle(0, 0, 0, 0, 0, '0, 0, '0, 1);
    idle(1);
    apply_reset();
    for (int k = 0; k < 3; k++) do_cycle(0, 1, 1, 0, 0, '0, 0, '0, 0);
    #1;
    check("post_rst_step_pc", o_pc, 8'd0);

    // Counter saturation and PC wrap.
    start_seq(0);
    idle(260);
    #1;
    check("cnt_saturated", o_cycle_count, 8'hFF);
    check("pc_wrapped", o_pc, 8'd4);
    do_cycle(0, 0, 0, 0, 0, '0, 1, 8'hFF, 0);
    idle(1);
    #1;
    check("pc_wrap_ff", o_pc, 8'd0);

    // Randomized traffic against the model.
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      logic r_start, r_mode, r_step, r_stall, r_jump, r_br, r_halt;
      r_start = ($urandom_range(0, 15) == 0);
      r_mode  = $urandom_range(0, 1);
      r_step  = $urandom_range(0, 1);
      r_stall = ($urandom_range(0, 4) == 0);
      r_jump  = ($urandom_range(0, 4) == 0);
      r_br    = ($urandom_range(0, 9) == 0);
      r_halt  = ($urandom_range(0, 19) == 0);
      do_cycle(r_start, r_mode, r_step, r_stall, r_jump, W'($urandom),
               r_br, W'($urandom), r_halt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
